// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Provides the FSM state enum, default width and divide-by-zero quotient.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // All-ones pattern; callers truncate to their width.
    // Reads as max unsigned, or -1 in two's complement.
    function automatic logic [63:0] dbz_quot();
        return '1;
    endfunction

endpackage

// File: rtl/div_iter_cnt.sv
// Iteration up-counter for the restoring divider.
// Ports: clk, reset (async active-low), clr, inc, tc (cnt==WIDTH-1).
module div_iter_cnt #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(WIDTH - 1));

    // Returning to zero on the terminal edge avoids wrap
    // when WIDTH is not a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || (inc && tc)) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, start/done handshake, WIDTH iterations.
// Ports: clk, reset (async active-low), start, dividend, divisor -> busy,
// done, quotient, remainder, div_by_zero. Macro SIGNED_DIV_EN: signed ops.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t state, state_nxt;

    logic [WIDTH-1:0] r, q, dvsr;
    logic [WIDTH-1:0] r_sh, r_nxt, q_nxt;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin, dbz_q;
    logic             accept, calc, tc, zdiv;

    assign accept = (state == IDLE) && start;
    assign calc   = (state == CALC);
    assign zdiv   = (divisor == '0);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign dbz_q  = WIDTH'(dbz_quot());

    div_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .inc   (calc),
        .tc    (tc)
    );

    // One restoring step: shift {R,Q}, trial subtract, keep or restore.
    assign r_sh  = {r[WIDTH-2:0], q[WIDTH-1]};
    assign trial = {1'b0, r_sh} - {1'b0, dvsr};
    assign r_nxt = trial[WIDTH] ? r_sh : trial[WIDTH-1:0];
    assign q_nxt = {q[WIDTH-2:0], ~trial[WIDTH]};

`ifdef SIGNED_DIV_EN
    logic neg_q, neg_r;

    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
    assign q_fin = neg_q ? -q_nxt : q_nxt;
    assign r_fin = neg_r ? -r_nxt : r_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fin = q_nxt;
    assign r_fin = r_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zdiv ? DONE : CALC;
                end
            end
            CALC: begin
                if (tc) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r           <= '0;
            q           <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            r    <= '0;
            q    <= a_mag;
            dvsr <= b_mag;
            // Divide-by-zero skips CALC and publishes at once.
            if (zdiv) begin
                quotient    <= dbz_q;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (calc) begin
            r <= r_nxt;
            q <= q_nxt;
            if (tc) begin
                quotient    <= q_fin;
                remainder   <= r_fin;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider.
// Directed plus random operations against an arithmetic reference.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] eq,
                                  output logic [W-1:0] er,
                                  output logic ez);
        int sa, sb;
`ifdef SIGNED_DIV_EN
        sa = $signed(a);
        sb = $signed(b);
`else
        sa = int'(a);
        sb = int'(b);
`endif
        if (b == '0) begin
            eq = '1;
            er = a;
            ez = 1'b1;
        end else begin
            eq = W'(sa / sb);
            er = W'(sa % sb);
            ez = 1'b0;
        end
    endfunction

    // ign: loop index at which a stray start (10/2) is pulsed; -1 none.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int ign);
        int n;
        logic [W-1:0] eq, er;
        logic ez;
        model(a, b, eq, er, ez);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            if (n == ign) begin
                start    = 1'b1;
                dividend = 8'd10;
                divisor  = 8'd2;
            end else begin
                start    = 1'b0;
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        check("latency", n, (b == '0) ? 0 : W);
        check("busy_at_done", busy, 1);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, ez);
        @(posedge clk);
        #1;
        check("done_pulse", done, 0);
        check("idle_after", busy, 0);
        check("quotient_hold", quotient, eq);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int seen;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op(8'd100, 8'd7, -1);
        run_op(8'd255, 8'd1, -1);
        run_op(8'd5, 8'd9, -1);
        run_op(8'h3C, 8'd0, -1);
        run_op(8'd200, 8'd3, 2);
        run_op(8'd10, 8'd2, -1);

        // Reset in the middle of an operation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_quot", quotient, 0);
        check("mid_rst_rem", remainder, 0);
        check("mid_rst_dbz", div_by_zero, 0);
        @(negedge clk);
        #3;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("no_done_after_rst", seen, 0);
        run_op(8'd100, 8'd7, -1);

`ifdef SIGNED_DIV_EN
        run_op(8'h9C, 8'd7, -1);
        run_op(8'h80, 8'hFF, -1);
        run_op(8'h9C, 8'h00, -1);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(ra, rb, (i % 5 == 0) ? 3 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
